// File: rtl/dac_seg_encoder.sv
// dac_seg_encoder
//   Segmented current-steering DAC encoder. A 12-bit code is clipped to the
//   usable full scale (2303) and split into 17 unary thermometer cells
//   (128 LSB each) plus a 7-bit binary LSB segment. With dem_en set, the
//   thermometer cells are selected by data-weighted averaging: each sample
//   turns on the next n cells after the rotation pointer, so that cell
//   mismatch is spread over time.
//
//   Two-stage pipeline: stage 1 clips and registers the code, stage 2 encodes
//   and drives the outputs. The outputs and sat only change on a valid sample.
//   The complement outputs are registered alongside their true outputs.
//
// Ports
//   clkin          in   sample clock (rising edge)
//   rst            in   asynchronous active-high reset
//   pdb            in   power-down bar, synchronous; 0 clears the pipeline
//   code_in[11:0]  in   unsigned DAC code
//   valid_in       in   code_in carries a new sample
//   dem_en         in   1 = DWA rotation, 0 = fixed thermometer (stage-2 aligned)
//   dataouttherm   out  17 thermometer cell enables
//   dataoutthermb  out  complement of dataouttherm
//   dataoutbin     out  7-bit binary LSB segment
//   dataoutbinb    out  complement of dataoutbin
//   valid_out      out  one-cycle pulse when the outputs take a new sample
//   sat            out  the sample on the outputs was clipped
module dac_seg_encoder #(
  parameter int PTR_INIT = 0
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        pdb,
  input  logic [11:0] code_in,
  input  logic        valid_in,
  input  logic        dem_en,
  output logic [16:0] dataouttherm,
  output logic [16:0] dataoutthermb,
  output logic [6:0]  dataoutbin,
  output logic [6:0]  dataoutbinb,
  output logic        valid_out,
  output logic        sat
);

  localparam logic [11:0] CODE_MAX = 12'd2303;
  localparam logic [4:0]  PTR_RST  = 5'(PTR_INIT);

  logic        s1_valid;
  logic [11:0] s1_code;
  logic        s1_sat;
  logic [4:0]  ptr;

  logic [4:0]  n;
  logic [6:0]  b;
  logic [16:0] mask;
  logic [33:0] rot_full;
  logic [16:0] therm_next;
  logic [5:0]  ptr_sum;
  logic [4:0]  ptr_next;

  // Stage 1: clip and register.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_sat   <= 1'b0;
    end else if (!pdb) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      s1_code  <= (code_in > CODE_MAX) ? CODE_MAX : code_in;
      s1_sat   <= (code_in > CODE_MAX);
    end
  end

  // Stage-2 encode. n is at most 17 because the code is clipped to 2303.
  always_comb begin
    n = s1_code[11:7];
    b = s1_code[6:0];
    mask = '0;
    for (int i = 0; i < 17; i++) begin
      mask[i] = (5'(i) < n);
    end
    // Rotate-left by ptr within 17 bits: the upper half of the doubled mask
    // shifted by ptr picks up the bits that wrapped past cell 16.
    rot_full   = {mask, mask} << ptr;
    therm_next = dem_en ? rot_full[33:17] : mask;
    // ptr <= 16 and n <= 17, so one conditional subtract is a full mod 17.
    ptr_sum    = {1'b0, ptr} + {1'b0, n};
    ptr_next   = (ptr_sum >= 6'd17) ? 5'(ptr_sum - 6'd17) : ptr_sum[4:0];
  end

  // Stage 2: output registers and rotation pointer.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      dataouttherm  <= '0;
      dataoutthermb <= '1;
      dataoutbin    <= '0;
      dataoutbinb   <= '1;
      valid_out     <= 1'b0;
      sat           <= 1'b0;
      ptr           <= PTR_RST;
    end else if (!pdb) begin
      dataouttherm  <= '0;
      dataoutthermb <= '1;
      dataoutbin    <= '0;
      dataoutbinb   <= '1;
      valid_out     <= 1'b0;
      sat           <= 1'b0;
      ptr           <= PTR_RST;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        dataouttherm  <= therm_next;
        dataoutthermb <= ~therm_next;
        dataoutbin    <= b;
        dataoutbinb   <= ~b;
        sat           <= s1_sat;
        if (dem_en) begin
          ptr <= ptr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_seg_encoder.sv
module tb_dac_seg_encoder;

  localparam int PTR_INIT = 0;

  logic        clkin = 1'b0;
  logic        rst = 1'b0;
  logic        pdb = 1'b1;
  logic [11:0] code_in = '0;
  logic        valid_in = 1'b0;
  logic        dem_en = 1'b0;
  logic [16:0] dataouttherm;
  logic [16:0] dataoutthermb;
  logic [6:0]  dataoutbin;
  logic [6:0]  dataoutbinb;
  logic        valid_out;
  logic        sat;

  dac_seg_encoder #(.PTR_INIT(PTR_INIT)) dut (
    .clkin         (clkin),
    .rst           (rst),
    .pdb           (pdb),
    .code_in       (code_in),
    .valid_in      (valid_in),
    .dem_en        (dem_en),
    .dataouttherm  (dataouttherm),
    .dataoutthermb (dataoutthermb),
    .dataoutbin    (dataoutbin),
    .dataoutbinb   (dataoutbinb),
    .valid_out     (valid_out),
    .sat           (sat)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [11:0] code;
    logic        dem;
    logic [16:0] therm;
    logic [6:0]  bin;
    logic        sat;
    logic [4:0]  ptr;
  } vec_t;

  typedef struct {
    logic [16:0] therm;
    logic [6:0]  bin;
    logic        sat;
    logic [4:0]  ptr;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[11];
  vec_t wrap[4];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic pdb_at_edge = 1'b1;
  bit   armed = 1'b0;

  logic [16:0] h_therm = '0;
  logic [6:0]  h_bin = '0;
  logic        h_sat = 1'b0;

  always @(posedge clkin) begin
    cyc = cyc + 1;
    pdb_at_edge = pdb;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [11:0] c, input logic v, input logic d, input logic p);
    @(posedge clkin);
    #1;
    code_in  = c;
    valid_in = v;
    dem_en   = d;
    pdb      = p;
  endtask

  // dem_en driven alongside a sample belongs to the previous sample (stage 2).
  task automatic send(input vec_t e, input logic d);
    exp_t x;
    step(e.code, 1'b1, d, 1'b1);
    x.therm = e.therm;
    x.bin   = e.bin;
    x.sat   = e.sat;
    x.ptr   = e.ptr;
    x.due   = cyc + 2;
    sb.push_back(x);
  endtask

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clkin) begin
    if (armed) begin
      exp_t e;
      chk("thermb_compl", 32'(dataoutthermb), 32'({~dataouttherm}));
      chk("binb_compl", 32'(dataoutbinb), 32'({~dataoutbin}));
      if (rst || !pdb_at_edge) begin
        sb.delete();
        h_therm = '0;
        h_bin   = '0;
        h_sat   = 1'b0;
        chk("ptr_init", 32'(dut.ptr), 32'(PTR_INIT));
      end
      if (valid_out) begin
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_valid: valid_out=1 with no sample expected (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("therm", 32'(dataouttherm), 32'(e.therm));
          chk("bin", 32'(dataoutbin), 32'(e.bin));
          chk("sat", 32'(sat), 32'(e.sat));
          chk("ptr", 32'(dut.ptr), 32'(e.ptr));
          chk("latency", 32'(cyc), 32'(e.due));
          h_therm = e.therm;
          h_bin   = e.bin;
          h_sat   = e.sat;
        end
      end else begin
        chk("hold_therm", 32'(dataouttherm), 32'(h_therm));
        chk("hold_bin", 32'(dataoutbin), 32'(h_bin));
        chk("hold_sat", 32'(sat), 32'(h_sat));
      end
    end
  end

  initial begin
    // code, dem_en, therm, bin, sat, ptr after the sample (starting from ptr 0)
    tbl[0]  = '{12'd165,  1'b0, 17'h00001, 7'h25, 1'b0, 5'd0};
    tbl[1]  = '{12'd4095, 1'b0, 17'h1FFFF, 7'h7F, 1'b1, 5'd0};
    tbl[2]  = '{12'd384,  1'b1, 17'h00007, 7'h00, 1'b0, 5'd3};
    tbl[3]  = '{12'd384,  1'b1, 17'h00038, 7'h00, 1'b0, 5'd6};
    tbl[4]  = '{12'd0,    1'b1, 17'h00000, 7'h00, 1'b0, 5'd6};
    tbl[5]  = '{12'd2303, 1'b1, 17'h1FFFF, 7'h7F, 1'b0, 5'd6};
    tbl[6]  = '{12'd2304, 1'b1, 17'h1FFFF, 7'h7F, 1'b1, 5'd6};
    tbl[7]  = '{12'd127,  1'b0, 17'h00000, 7'h7F, 1'b0, 5'd6};
    tbl[8]  = '{12'd1000, 1'b0, 17'h0007F, 7'h68, 1'b0, 5'd6};
    tbl[9]  = '{12'd1000, 1'b1, 17'h01FC0, 7'h68, 1'b0, 5'd13};
    tbl[10] = '{12'd700,  1'b1, 17'h1E001, 7'h3C, 1'b0, 5'd1};

    wrap[0] = '{12'd640, 1'b1, 17'h0001F, 7'h00, 1'b0, 5'd5};
    wrap[1] = '{12'd640, 1'b1, 17'h003E0, 7'h00, 1'b0, 5'd10};
    wrap[2] = '{12'd640, 1'b1, 17'h07C00, 7'h00, 1'b0, 5'd15};
    wrap[3] = '{12'd512, 1'b1, 17'h18003, 7'h00, 1'b0, 5'd2};

    // Asynchronous reset, checked before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("rst_therm", 32'(dataouttherm), 32'h00000);
    chk("rst_thermb", 32'(dataoutthermb), 32'h1FFFF);
    chk("rst_bin", 32'(dataoutbin), 32'h00);
    chk("rst_binb", 32'(dataoutbinb), 32'h7F);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_sat", 32'(sat), 32'h0);
    armed = 1'b1;
    step(12'd0, 1'b0, 1'b0, 1'b1);
    step(12'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    step(12'd0, 1'b0, 1'b0, 1'b1);

    // Back-to-back table vectors.
    for (int i = 0; i < 11; i++) begin
      send(tbl[i], (i > 0) ? tbl[i-1].dem : 1'b0);
    end
    step(12'd0, 1'b0, tbl[10].dem, 1'b1);
    for (int i = 0; i < 4; i++) step(12'd0, 1'b0, 1'b0, 1'b1);

    // Power-down with a sample in stage 1; valid_in ignored while down.
    send('{12'd1000, 1'b0, 17'h0007F, 7'h68, 1'b0, 5'd1}, 1'b0);
    step(12'd0, 1'b0, 1'b0, 1'b0);
    step(12'd4095, 1'b1, 1'b0, 1'b0);
    step(12'd4095, 1'b1, 1'b0, 1'b0);
    step(12'd0, 1'b0, 1'b0, 1'b1);
    send('{12'd165, 1'b0, 17'h00001, 7'h25, 1'b0, 5'd0}, 1'b0);
    for (int i = 0; i < 4; i++) step(12'd0, 1'b0, 1'b0, 1'b1);

    // DWA wrap-around from ptr 0.
    step(12'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(wrap[i], 1'b1);
    step(12'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(12'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation: in-flight sample must never appear.
    send('{12'd700, 1'b0, 17'h0001F, 7'h3C, 1'b0, 5'd2}, 1'b0);
    step(12'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    step(12'd0, 1'b0, 1'b0, 1'b1);
    step(12'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    step(12'd0, 1'b0, 1'b0, 1'b1);
    send('{12'd4095, 1'b0, 17'h1FFFF, 7'h7F, 1'b1, 5'd0}, 1'b0);
    step(12'd0, 1'b0, 1'b0, 1'b1);

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(posedge clkin);
        n++;
      end
      if (sb.size() != 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL drain: %0d samples outstanding, required 0", sb.size());
      end
    end
    for (int i = 0; i < 3; i++) step(12'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clkin);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_seg_encoder.md
DAC_SEG_ENCODER -- requirements
Module: dac_seg_encoder

Interface
REQ-001 Parameter: PTR_INIT, default 0, DWA rotation pointer value loaded on reset and power-down (legal range 0..16).
REQ-002 Port: clkin  input  1  sample clock; all state SHALL be updated on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: pdb  input  1  power-down bar; 0 = powered down.
REQ-005 Port: code_in  input  12  unsigned DAC code.
REQ-006 Port: valid_in  input  1  code_in is a new sample this cycle.
REQ-007 Port: dem_en  input  1  1 = data-weighted-averaging rotation of thermometer cells; 0 = fixed thermometer.
REQ-008 Port: dataouttherm  output  17  thermometer cell enables, unit weight 128 LSB.
REQ-009 Port: dataoutthermb  output  17  bitwise complement of dataouttherm.
REQ-010 Port: dataoutbin  output  7  binary LSB segment.
REQ-011 Port: dataoutbinb  output  7  bitwise complement of dataoutbin.
REQ-012 Port: valid_out  output  1  one-cycle pulse when outputs take a new sample.
REQ-013 Port: sat  output  1  the sample on the outputs was clipped, aligned with the data.

Function
REQ-014 The block SHALL be a 2-stage pipeline; latency is exactly 2 clkin cycles from a valid_in=1 sample to its valid_out=1 cycle.
REQ-015 Stage 1 SHALL register the clipped code c = min(code_in, 2303), valid_in, and s1_sat = (code_in > 2303).
REQ-016 Stage 2 SHALL derive n = c[11:7] (range 0..17) and b = c[6:0].
REQ-017 dataoutbin SHALL be b.
REQ-018 With dem_en=0, dataouttherm SHALL have bits 0..n-1 set and all others clear; the pointer SHALL hold.
REQ-019 With dem_en=1, dataouttherm SHALL have bits (ptr+k) mod 17 set for k = 0..n-1.
REQ-020 With dem_en=1, the pointer SHALL update to (ptr+n) mod 17 on the same edge.
REQ-021 n=0 SHALL give an all-zero dataouttherm and leave ptr unchanged.
REQ-022 n=17 SHALL set all 17 cells; ptr is unchanged.
REQ-023 The pointer SHALL be a 5-bit register that never holds a value above 16.
REQ-024 dem_en SHALL be sampled in stage 2, aligned with the sample it affects.
REQ-025 Stage-2 registers SHALL update only when the stage-1 valid is 1; otherwise all data outputs and sat hold their previous values and valid_out=0.
REQ-026 Complement outputs SHALL be registered together with their true outputs, so that dataoutthermb == ~dataouttherm and dataoutbinb == ~dataoutbin on every cycle.
REQ-027 Back-to-back valid_in=1 SHALL be accepted every cycle with no bubbles; there is no backpressure.
REQ-028 pdb=0, sampled synchronously, SHALL on the next edge:
  - clear both pipeline stages
  - set the data outputs to the code-0 state (therm 0, thermb 0x1FFFF, bin 0, binb 0x7F)
  - clear sat and valid_out
  - load ptr with PTR_INIT
REQ-029 While pdb=0, valid_in SHALL be ignored.
REQ-030 After pdb rises, the first accepted sample SHALL appear 2 cycles later.

Reset
REQ-031 rst=1 SHALL asynchronously force:
  - dataouttherm=0, dataoutthermb=0x1FFFF
  - dataoutbin=0, dataoutbinb=0x7F
  - valid_out=0, sat=0
  - ptr=PTR_INIT
  - stage-1 valid=0
REQ-032 Reset asserted mid-operation SHALL discard any in-flight sample; no valid_out pulse for that sample SHALL appear after release.
REQ-033 After rst deasserts, the first valid_in=1 sample SHALL produce valid_out exactly 2 edges later.

Verification
REQ-034 Reset check: assert rst → therm=0x00000, thermb=0x1FFFF, bin=0x00, binb=0x7F, valid_out=0, sat=0, immediately and without a clock edge.
REQ-035 Basic sample: pdb=1, dem_en=0, code_in=165 with one valid_in pulse → 2 cycles later therm=0x00001, bin=0x25, binb=0x5A, sat=0, valid_out=1 for one cycle; outputs hold afterwards.
REQ-036 Saturation: code_in=4095 → therm=0x1FFFF, thermb=0x00000, bin=0x7F, sat=1.
REQ-037 DWA sequence: dem_en=1, PTR_INIT=0, code 384 twice back-to-back → therm=0x00007 and then 0x00038 on consecutive cycles; ptr ends at 6.
REQ-038 DWA wrap-around:
  - stimulus: dem_en=1, from ptr 0 send code 640 three times, then code 512
  - check: ptr reaches 15 after the three code-640 samples
  - check: the code-512 sample gives therm=0x18003 and ptr=2
REQ-039 Power-down mid-stream: drop pdb with a sample in stage 1 → next edge outputs return to the code-0 state, valid_out stays 0, ptr=PTR_INIT; after pdb rises, a new sample emerges with 2-cycle latency.
